// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares the writeback port between the pipeline
// and a one-entry multiply/divide result buffer with bounded starvation.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk_in,
  input  logic              Rst,
  input  logic              RegWrite_in_WB,
  input  logic [ADDR_W-1:0] WriteReg_in_WB,
  input  logic [DATA_W-1:0] WriteData_in_WB,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              RegWrite_out,
  output logic [ADDR_W-1:0] WriteReg_out,
  output logic [DATA_W-1:0] WriteData_out,
  output logic              Stall_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX - 1);

  state_t            state_r;
  logic [3:0]        wcnt_r;
  logic [ADDR_W-1:0] buf_reg_r;
  logic [DATA_W-1:0] buf_data_r;

  logic              live_s;
  logic              hit_held_s;
  logic              hit_md_s;
  logic              handshake_s;
  logic              sel_buf_s;
  logic [ADDR_W-1:0] sel_reg_s;

  function automatic logic addr_nonzero(input logic [ADDR_W-1:0] a);
    return (a != {ADDR_W{1'b0}});
  endfunction

  assign live_s      = RegWrite_in_WB && addr_nonzero(WriteReg_in_WB);
  assign hit_held_s  = live_s && (WriteReg_in_WB == buf_reg_r);
  assign hit_md_s    = live_s && (WriteReg_in_WB == md_reg);
  assign handshake_s = md_valid && md_ready;

  // Port selection, handshake readiness and stall; all gated off while in reset.
  always_comb begin
    sel_buf_s = 1'b0;
    md_ready  = 1'b0;
    Stall_out = 1'b0;
    case (state_r)
      ST_IDLE: begin
        md_ready = Rst;
      end
      ST_HELD: begin
        sel_buf_s = !live_s;
      end
      ST_FORCE: begin
        sel_buf_s = 1'b1;
        Stall_out = Rst;
      end
      default: begin
        sel_buf_s = 1'b0;
      end
    endcase
    sel_reg_s     = sel_buf_s ? buf_reg_r : WriteReg_in_WB;
    WriteReg_out  = sel_reg_s;
    WriteData_out = sel_buf_s ? buf_data_r : WriteData_in_WB;
    if (sel_buf_s) begin
      RegWrite_out = Rst && addr_nonzero(sel_reg_s);
    end else begin
      RegWrite_out = Rst && live_s;
    end
  end

  // Arbitration state, starvation counter and the one-entry result buffer.
  always_ff @(posedge Clk_in or negedge Rst) begin
    if (!Rst) begin
      state_r    <= ST_IDLE;
      wcnt_r     <= 4'd0;
      buf_reg_r  <= {ADDR_W{1'b0}};
      buf_data_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A same-cycle pipeline write to md_reg is younger and supersedes the result.
          if (handshake_s && addr_nonzero(md_reg) && !hit_md_s) begin
            buf_reg_r  <= md_reg;
            buf_data_r <= md_data;
            wcnt_r     <= 4'd0;
            state_r    <= ST_HELD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!live_s || hit_held_s) begin
            wcnt_r  <= 4'd0;
            state_r <= ST_IDLE;
          end else if (wcnt_r == STARVE_LIM) begin
            wcnt_r  <= wcnt_r + 4'd1;
            state_r <= ST_FORCE;
          end else begin
            wcnt_r  <= wcnt_r + 4'd1;
            state_r <= ST_HELD;
          end
        end
        ST_FORCE: begin
          wcnt_r  <= 4'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          wcnt_r  <= 4'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (STARVE_MAX=4).
module tb_wb_port_arbiter;

  logic        Clk_in = 1'b0;
  logic        Rst;
  logic        RegWrite_in_WB;
  logic [4:0]  WriteReg_in_WB;
  logic [31:0] WriteData_in_WB;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        RegWrite_out;
  logic [4:0]  WriteReg_out;
  logic [31:0] WriteData_out;
  logic        Stall_out;

  int n_tests = 0;
  int n_fail  = 0;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)) dut (
    .Clk_in          (Clk_in),
    .Rst             (Rst),
    .RegWrite_in_WB  (RegWrite_in_WB),
    .WriteReg_in_WB  (WriteReg_in_WB),
    .WriteData_in_WB (WriteData_in_WB),
    .md_valid        (md_valid),
    .md_reg          (md_reg),
    .md_data         (md_data),
    .md_ready        (md_ready),
    .RegWrite_out    (RegWrite_out),
    .WriteReg_out    (WriteReg_out),
    .WriteData_out   (WriteData_out),
    .Stall_out       (Stall_out)
  );

  always #5 Clk_in = ~Clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_in);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [4:0] r, input logic [31:0] d);
    RegWrite_in_WB  = we;
    WriteReg_in_WB  = r;
    WriteData_in_WB = d;
  endtask

  task automatic md(input logic v, input logic [4:0] r, input logic [31:0] d);
    md_valid = v;
    md_reg   = r;
    md_data  = d;
    #2;
  endtask

  initial begin
    // Reset with a live pipeline write presented
    Rst = 1'b0;
    pipe(1'b1, 5'd5, 32'h0000_0011);
    md(1'b0, 5'd0, 32'h0);
    tick(); tick();
    #2;
    chk("rst_regwrite", {31'd0, RegWrite_out}, 32'd0);
    chk("rst_md_ready", {31'd0, md_ready}, 32'd0);
    chk("rst_stall", {31'd0, Stall_out}, 32'd0);
    tick();
    Rst = 1'b1;
    tick();
    #2;
    chk("idle_regwrite", {31'd0, RegWrite_out}, 32'd1);
    chk("idle_wreg", {27'd0, WriteReg_out}, 32'd5);
    chk("idle_md_ready", {31'd0, md_ready}, 32'd1);
    // Pipeline write to register 0 is dropped
    tick();
    pipe(1'b1, 5'd0, 32'h0000_0022);
    #2;
    chk("pipe_r0", {31'd0, RegWrite_out}, 32'd0);

    // Free port: result written in the next cycle
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    md(1'b1, 5'd7, 32'h0000_0064);
    chk("free_hs_ready", {31'd0, md_ready}, 32'd1);
    chk("free_hs_nowr", {31'd0, RegWrite_out}, 32'd0);
    tick();
    md(1'b0, 5'd1, 32'hDEAD_BEEF);
    chk("free_wr", {31'd0, RegWrite_out}, 32'd1);
    chk("free_wreg", {27'd0, WriteReg_out}, 32'd7);
    chk("free_wdata", WriteData_out, 32'h0000_0064);
    chk("free_busy", {31'd0, md_ready}, 32'd0);
    tick();
    #2;
    chk("free_ready_back", {31'd0, md_ready}, 32'd1);
    chk("free_no_rewr", {31'd0, RegWrite_out}, 32'd0);

    // Starvation: four pipeline wins then a forced buffer write
    tick();
    md(1'b1, 5'd9, 32'h0000_0099);
    tick();
    pipe(1'b1, 5'd3, 32'h0000_0033);
    md(1'b0, 5'd0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      chk("starve_wr", {31'd0, RegWrite_out}, 32'd1);
      chk("starve_wreg", {27'd0, WriteReg_out}, 32'd3);
      chk("starve_nostall", {31'd0, Stall_out}, 32'd0);
      tick();
      #2;
    end
    chk("force_stall", {31'd0, Stall_out}, 32'd1);
    chk("force_wr", {31'd0, RegWrite_out}, 32'd1);
    chk("force_wreg", {27'd0, WriteReg_out}, 32'd9);
    chk("force_wdata", WriteData_out, 32'h0000_0099);
    chk("force_busy", {31'd0, md_ready}, 32'd0);
    tick();
    #2;
    chk("after_force_wreg", {27'd0, WriteReg_out}, 32'd3);
    chk("after_force_wr", {31'd0, RegWrite_out}, 32'd1);
    chk("after_force_stall", {31'd0, Stall_out}, 32'd0);
    chk("after_force_ready", {31'd0, md_ready}, 32'd1);

    // WAW cancel: younger pipeline write to the buffered register
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    md(1'b1, 5'd12, 32'h0000_AAAA);
    tick();
    pipe(1'b1, 5'd12, 32'h0000_5555);
    md(1'b0, 5'd0, 32'h0);
    chk("waw_wreg", {27'd0, WriteReg_out}, 32'd12);
    chk("waw_wdata", WriteData_out, 32'h0000_5555);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    #2;
    chk("waw_no_buf_wr", {31'd0, RegWrite_out}, 32'd0);
    chk("waw_idle", {31'd0, md_ready}, 32'd1);
    tick();
    #2;
    chk("waw_no_buf_wr2", {31'd0, RegWrite_out}, 32'd0);

    // Same-cycle conflict in IDLE: result discarded
    tick();
    pipe(1'b1, 5'd4, 32'h0000_4040);
    md(1'b1, 5'd4, 32'h0000_0044);
    chk("conf_wreg", {27'd0, WriteReg_out}, 32'd4);
    chk("conf_wdata", WriteData_out, 32'h0000_4040);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    md(1'b0, 5'd0, 32'h0);
    chk("conf_no_buf_wr", {31'd0, RegWrite_out}, 32'd0);
    chk("conf_idle", {31'd0, md_ready}, 32'd1);

    // Result to register 0 is discarded
    tick();
    md(1'b1, 5'd0, 32'h0000_0077);
    chk("r0_hs_nowr", {31'd0, RegWrite_out}, 32'd0);
    tick();
    md(1'b0, 5'd0, 32'h0);
    chk("r0_nowr", {31'd0, RegWrite_out}, 32'd0);
    chk("r0_idle", {31'd0, md_ready}, 32'd1);

    // Reset while HELD loses the buffered result
    tick();
    md(1'b1, 5'd6, 32'h0000_0066);
    tick();
    pipe(1'b1, 5'd2, 32'h0000_0002);
    md(1'b0, 5'd0, 32'h0);
    chk("held_pipe_wreg", {27'd0, WriteReg_out}, 32'd2);
    chk("held_busy", {31'd0, md_ready}, 32'd0);
    Rst = 1'b0;
    #1;
    chk("midrst_wr", {31'd0, RegWrite_out}, 32'd0);
    chk("midrst_ready", {31'd0, md_ready}, 32'd0);
    chk("midrst_stall", {31'd0, Stall_out}, 32'd0);
    tick();
    Rst = 1'b1;
    pipe(1'b0, 5'd0, 32'h0);
    #2;
    chk("postrst_nowr", {31'd0, RegWrite_out}, 32'd0);
    chk("postrst_ready", {31'd0, md_ready}, 32'd1);
    tick();
    #2;
    chk("postrst_nowr2", {31'd0, RegWrite_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
